dr_pfreq_queue: RTL and testbench
=================================

Name: dr_pfreq_queue

Overview:
- Buffers prefetch requests from the directory bank's drtomem_pfreq port and issues them to the memory-side drtomem_pfreq port.
- Sits between the directory bank and memory.
- Never back-pressures the directory: when full it drops the oldest queued prefetch. It also filters duplicate lines and squashes queued prefetches made redundant by demand requests to memory.

Parameters:
PADDR_W, 50, physical address width (SC_paddr_type)
DEPTH, 4, queue slots; power of two, legal 4/8/16
LINE_OFF, 6, line offset bits (64B line); line address = paddr[PADDR_W-1:LINE_OFF]
CNT_W, 16, drop counter width

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
pf_in_valid  in  1  prefetch from directory (drtomem_pfreq_valid)
pf_in_retry  out  1  retry to directory
pf_in_paddr  in  PADDR_W  prefetch address
dem_valid  in  1  demand request to memory, observed (drtomem_req_valid & ~drtomem_req_retry)
dem_paddr  in  PADDR_W  demand address
pf_out_valid  out  1  prefetch to memory
pf_out_retry  in  1  memory retry
pf_out_paddr  out  PADDR_W  prefetch address to memory
drop_cnt  out  CNT_W  saturating count of overflow drops

Behaviour:
- Handshake: a transfer occurs when valid && !retry. Out stage holds pf_out_valid/pf_out_paddr stable until accepted.
- Reset (async): all slot valid bits 0, head=tail=0, occupancy=0, out stage empty.
  - Reset values: pf_out_valid=0, pf_out_paddr=0, drop_cnt=0, pf_in_retry=1.
  - pf_in_retry is a register, cleared on the first clock edge after reset deasserts; it stays 0 from then on.
- Storage:
  - Circular buffer of DEPTH slots, each {v, paddr}; head/tail pointers log2(DEPTH) bits, wrapping modulo DEPTH.
  - occ = number of slots between head and tail (0..DEPTH). Squashed slots stay occupied (v=0) until head passes them.
  - full = occ==DEPTH.
- Push (pf_in_valid && !pf_in_retry): incoming paddr is discarded (no state change) when its line matches any of:
  - a valid slot,
  - the out stage,
  - dem_paddr while dem_valid is high in the same cycle.
- Otherwise the paddr is written to slot[tail] with v=1, and tail increments.
- Pop/load: when the out stage is empty or accepted this cycle, and occ>0:
  - if slot[head].v=1, load it into the out stage;
  - if slot[head].v=0, skip it (nothing loaded).
  - In both cases head increments; at most one slot is consumed per cycle.
- Overflow: push accepted while full and no pop this cycle:
  - slot[head] is overwritten logic-wise: head increments, the new entry goes to tail (the old head slot position), occ stays DEPTH.
  - drop_cnt increments, saturating at 2^CNT_W-1.
  - A drop occurs even if the dropped slot was already v=0.
- Push while full with a pop in the same cycle: no drop; occ unchanged.
- Demand squash: dem_valid clears v of every valid slot whose line matches dem_paddr. The out stage is never squashed.
- Same-cycle push and pop: both happen. The pushed slot is not loadable in the same cycle.
- Minimum latency: pf_in accepted at edge N -> pf_out_valid=1 after edge N+1 (empty queue, empty out stage).
- Matching compares line addresses only (offset bits ignored). The out stage stores the full paddr.
- Reset mid-operation: all queued and out-stage requests are lost, with no indication; drop_cnt returns to 0.

Test Plan:
1. Reset release, single push 0x1000 with pf_out_retry=0 -> pf_in_retry=0 after one edge; pf_out_valid high exactly 2 cycles after push, paddr 0x1000, one cycle.
2. DEPTH=4, pf_out_retry=1, push 0x1000,0x2000,...,0x6000 -> out stage holds 0x1000; queue then full with 0x2000..0x5000; push 0x6000 drops 0x2000, drop_cnt=1. Release retry -> out order 0x1000,0x3000,0x4000,0x5000,0x6000.
3. Push 0x1040 then 0x1078 (same line) -> second discarded; only 0x1040 issued; drop_cnt=0.
4. Queue 0x2000,0x3000 behind a held out stage, dem_valid with 0x3010 -> 0x3000 squashed; after retry release only 0x2000 issued, then a skip cycle.
5. Full queue, pf_out_retry=0 and push in same cycle -> no drop, drop_cnt unchanged, occ stays 4.
6. Assert reset while 3 entries queued and pf_out_valid=1 -> outputs immediately 0/1 per reset values; no stale entry issued after release.

Source files
------------

// File: rtl/dr_pfreq_queue.sv
// Prefetch request queue between the directory bank and memory: drops the oldest entry on overflow,
// filters duplicate lines, and squashes queued lines that a demand request has already fetched.
module dr_pfreq_queue #(
    parameter int PADDR_W  = 50,
    parameter int DEPTH    = 4,
    parameter int LINE_OFF = 6,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pf_in_valid,
    output logic               pf_in_retry,
    input  logic [PADDR_W-1:0] pf_in_paddr,
    input  logic               dem_valid,
    input  logic [PADDR_W-1:0] dem_paddr,
    output logic               pf_out_valid,
    input  logic               pf_out_retry,
    output logic [PADDR_W-1:0] pf_out_paddr,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0]   slot_v;
    logic [PADDR_W-1:0] slot_paddr [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W:0]     occ;

    logic [DEPTH-1:0]   dem_hit;
    logic [DEPTH-1:0]   in_hit;
    logic [DEPTH-1:0]   slot_v_nxt;
    logic [PTR_W:0]     occ_nxt;
    logic               push_req;
    logic               dup;
    logic               push_ok;
    logic               full;
    logic               out_free;
    logic               out_acc;
    logic               pop;
    logic               load;
    logic               drop;

    function automatic logic same_line(input logic [PADDR_W-1:0] a, input logic [PADDR_W-1:0] b);
        return a[PADDR_W-1:LINE_OFF] == b[PADDR_W-1:LINE_OFF];
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            dem_hit[i] = dem_valid && slot_v[i] && same_line(slot_paddr[i], dem_paddr);
            in_hit[i]  = slot_v[i] && same_line(slot_paddr[i], pf_in_paddr);
        end
    end

    always_comb begin
        push_req = pf_in_valid && !pf_in_retry;
        dup      = (|in_hit)
                 || (pf_out_valid && same_line(pf_out_paddr, pf_in_paddr))
                 || (dem_valid && same_line(dem_paddr, pf_in_paddr));
        push_ok  = push_req && !dup;
        full     = (occ == OCC_FULL);
        out_acc  = pf_out_valid && !pf_out_retry;
        out_free = !pf_out_valid || !pf_out_retry;
        pop      = out_free && (occ != '0);
        // A slot being squashed this cycle is already covered by the demand, so never load it.
        load     = pop && slot_v[head] && !dem_hit[head];
        drop     = push_ok && full && !pop;
    end

    always_comb begin
        slot_v_nxt = slot_v & ~dem_hit;
        if (pop) begin
            slot_v_nxt[head] = 1'b0;
        end
        if (push_ok) begin
            slot_v_nxt[tail] = 1'b1;
        end
        occ_nxt = occ;
        if (push_ok && !drop && !pop) begin
            occ_nxt = occ + 1'b1;
        end else if (pop && !push_ok) begin
            occ_nxt = occ - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_v       <= '0;
            head         <= '0;
            tail         <= '0;
            occ          <= '0;
            pf_in_retry  <= 1'b1;
            pf_out_valid <= 1'b0;
            pf_out_paddr <= '0;
            drop_cnt     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_paddr[i] <= '0;
            end
        end else begin
            pf_in_retry <= 1'b0;
            slot_v      <= slot_v_nxt;
            occ         <= occ_nxt;
            if (push_ok) begin
                slot_paddr[tail] <= pf_in_paddr;
                tail             <= tail + 1'b1;
            end
            // On overflow the head advances past the dropped slot, which the new entry reuses.
            if (pop || drop) begin
                head <= head + 1'b1;
            end
            if (load) begin
                pf_out_valid <= 1'b1;
                pf_out_paddr <= slot_paddr[head];
            end else if (out_acc) begin
                pf_out_valid <= 1'b0;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dr_pfreq_queue.sv
// Directed bench for dr_pfreq_queue: a queue-based reference model checked every cycle,
// plus literal expectations and issue-order logs for each scenario.
module tb_dr_pfreq_queue;

    localparam int PADDR_W = 50;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 16;

    typedef logic [PADDR_W-1:0] addr_t;
    typedef addr_t addr_q_t[$];
    typedef struct {
        bit    v;
        addr_t a;
    } ent_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             pf_in_valid;
    logic             pf_in_retry;
    addr_t            pf_in_paddr;
    logic             dem_valid;
    addr_t            dem_paddr;
    logic             pf_out_valid;
    logic             pf_out_retry;
    addr_t            pf_out_paddr;
    logic [CNT_W-1:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    dr_pfreq_queue #(.PADDR_W(PADDR_W), .DEPTH(DEPTH), .LINE_OFF(6), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .pf_in_valid(pf_in_valid), .pf_in_retry(pf_in_retry), .pf_in_paddr(pf_in_paddr),
        .dem_valid(dem_valid), .dem_paddr(dem_paddr),
        .pf_out_valid(pf_out_valid), .pf_out_retry(pf_out_retry), .pf_out_paddr(pf_out_paddr),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model
    ent_t             q[$];
    logic             m_ov   = 1'b0;
    addr_t            m_op   = '0;
    logic [CNT_W-1:0] m_drop = '0;
    logic             m_inr  = 1'b1;
    bit               m_push, m_dup, m_pop, m_acc;
    ent_t             m_e;

    function automatic bit line_eq(input addr_t a, input addr_t b);
        return (a >> 6) == (b >> 6);
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            q.delete();
            m_ov = 1'b0; m_op = '0; m_drop = '0; m_inr = 1'b1;
        end else begin
            m_push = pf_in_valid && !m_inr;
            m_dup  = (m_ov && line_eq(m_op, pf_in_paddr)) || (dem_valid && line_eq(dem_paddr, pf_in_paddr));
            foreach (q[i]) if (q[i].v && line_eq(q[i].a, pf_in_paddr)) m_dup = 1;
            if (dem_valid) foreach (q[i]) if (line_eq(q[i].a, dem_paddr)) q[i].v = 0;
            m_acc = m_ov && !pf_out_retry;
            m_pop = (!m_ov || !pf_out_retry) && q.size() > 0;
            if (m_acc) m_ov = 1'b0;
            if (m_pop) begin
                m_e = q.pop_front();
                if (m_e.v) begin
                    m_ov = 1'b1;
                    m_op = m_e.a;
                end
            end
            if (m_push && !m_dup) begin
                if (q.size() == DEPTH) begin
                    void'(q.pop_front());
                    if (m_drop != '1) m_drop = m_drop + 1'b1;
                end
                m_e.v = 1; m_e.a = pf_in_paddr;
                q.push_back(m_e);
            end
            m_inr = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        chk("pf_in_retry", 64'(pf_in_retry), 64'(m_inr));
        chk("pf_out_valid", 64'(pf_out_valid), 64'(m_ov));
        chk("pf_out_paddr", 64'(pf_out_paddr), 64'(m_op));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    end

    addr_t out_log[$];
    initial forever begin
        @(negedge clk);
        #1;
        if (!reset && pf_out_valid && !pf_out_retry) out_log.push_back(pf_out_paddr);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input addr_t a);
        pf_in_valid = 1'b1;
        pf_in_paddr = a;
        tick();
        pf_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        pf_in_valid = 0; pf_in_paddr = '0; dem_valid = 0; dem_paddr = '0; pf_out_retry = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        out_log.delete();
    endtask

    task automatic check_log(input string nm, input addr_q_t exp);
        chk({nm, "_count"}, 64'(out_log.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < out_log.size(); i++)
            chk($sformatf("%s_%0d", nm, i), 64'(out_log[i]), 64'(exp[i]));
    endtask

    initial begin
        reset = 1'b1;
        pf_in_valid = 0; pf_in_paddr = '0; dem_valid = 0; dem_paddr = '0; pf_out_retry = 0;
        repeat (2) tick();
        chk("rst_in_retry", 64'(pf_in_retry), 64'd1);
        chk("rst_out_valid", 64'(pf_out_valid), 64'd0);
        reset = 1'b0;
        tick();
        chk("retry_cleared", 64'(pf_in_retry), 64'd0);

        // single push latency
        out_log.delete();
        push(50'h1000);
        chk("t1_not_yet", 64'(pf_out_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(pf_out_valid), 64'd1);
        chk("t1_paddr", 64'(pf_out_paddr), 64'h1000);
        tick();
        chk("t1_one_cycle", 64'(pf_out_valid), 64'd0);
        check_log("t1_log", '{50'h1000});

        // overflow drops oldest queued
        do_reset();
        pf_out_retry = 1;
        for (int k = 1; k <= 6; k++) push(addr_t'(k * 'h1000));
        chk("t2_drop", 64'(drop_cnt), 64'd1);
        chk("t2_held", 64'(pf_out_paddr), 64'h1000);
        pf_out_retry = 0;
        repeat (8) tick();
        check_log("t2_log", '{50'h1000, 50'h3000, 50'h4000, 50'h5000, 50'h6000});

        // duplicate line filtered
        do_reset();
        push(50'h1040);
        push(50'h1078);
        repeat (4) tick();
        check_log("t3_log", '{50'h1040});
        chk("t3_drop", 64'(drop_cnt), 64'd0);

        // demand squash
        do_reset();
        pf_out_retry = 1;
        push(50'h1000); push(50'h2000); push(50'h3000);
        dem_valid = 1; dem_paddr = 50'h3010;
        tick();
        dem_valid = 0;
        pf_out_retry = 0;
        repeat (6) tick();
        check_log("t4_log", '{50'h1000, 50'h2000});

        // push while full with pop: no drop
        do_reset();
        pf_out_retry = 1;
        for (int k = 1; k <= 5; k++) push(addr_t'(k * 'h1000));
        chk("t5_drop_pre", 64'(drop_cnt), 64'd0);
        pf_out_retry = 0;
        push(50'h7000);
        chk("t5_drop_post", 64'(drop_cnt), 64'd0);
        repeat (8) tick();
        check_log("t5_log", '{50'h1000, 50'h2000, 50'h3000, 50'h4000, 50'h5000, 50'h7000});

        // duplicate against out stage and same-cycle demand
        do_reset();
        pf_out_retry = 1;
        push(50'h8000);
        tick();
        push(50'h8020);
        dem_valid = 1; dem_paddr = 50'h9004;
        push(50'h9000);
        dem_valid = 0;
        pf_out_retry = 0;
        repeat (4) tick();
        check_log("t7_log", '{50'h8000});

        // reset mid-operation
        do_reset();
        pf_out_retry = 1;
        for (int k = 1; k <= 4; k++) push(addr_t'(k * 'h1000));
        chk("t6_pre_valid", 64'(pf_out_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(pf_out_valid), 64'd0);
        chk("t6_rst_paddr", 64'(pf_out_paddr), 64'd0);
        chk("t6_rst_retry", 64'(pf_in_retry), 64'd1);
        chk("t6_rst_drop", 64'(drop_cnt), 64'd0);
        tick();
        reset = 1'b0;
        pf_out_retry = 0;
        out_log.delete();
        repeat (6) tick();
        check_log("t6_log", '{});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
